// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and helpers for the multi-port GPR file
package rf_pkg;

  // Word and register-address widths of the MIPS32 GPR file
  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;

  // $zero: reads as zero, ignores writes, never tracked as busy
  localparam int ZERO_ADDR = 0;

  // Highest set bit of a port-hit vector, or -1 when no port hits.
  // Write ports are ordered so that a higher index has higher priority.
  function automatic int prio_sel(input logic [31:0] hit);
    int r;
    r = -1;
    for (int i = 0; i < 32; i++) begin
      if (hit[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - write/read/issue bus of the multi-port GPR file
interface regfile_mp_if #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NR = 4,
  parameter int NW = 2
);
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic [NR-1:0]    re;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;
  logic [NW-1:0]    iss_en;
  logic [NW*AW-1:0] iss_addr;
  logic             sb_empty;

  // Pipeline side (ID/WB) drives requests and sees read results
  modport master (
    output we, waddr, wdata, re, raddr, iss_en, iss_addr,
    input  rdata, rbusy, sb_empty
  );

  // Register file side
  modport slave (
    input  we, waddr, wdata, re, raddr, iss_en, iss_addr,
    output rdata, rbusy, sb_empty
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - busy bit per register for in-flight producers
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int NW = 2,
  localparam int NREGS = 2 ** AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NW-1:0]    we,
  input  logic [NW*AW-1:0] waddr,
  input  logic [NW-1:0]    iss_en,
  input  logic [NW*AW-1:0] iss_addr,
  output logic [NREGS-1:0] busy,
  output logic             sb_empty
);

  logic [NREGS-1:0] busy_nxt;

  // Next busy vector: writebacks clear first, then issues set, so a new
  // producer supersedes a retiring one on the same register
  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < NW; i++) begin
      if (we[i] && waddr[i*AW +: AW] != AW'(ZERO_ADDR))
        busy_nxt[waddr[i*AW +: AW]] = 1'b0;
    end
    for (int k = 0; k < NW; k++) begin
      if (iss_en[k] && iss_addr[k*AW +: AW] != AW'(ZERO_ADDR))
        busy_nxt[iss_addr[k*AW +: AW]] = 1'b1;
    end
  end

  // Busy register and empty flag, both taken from the same next state
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      sb_empty <= 1'b1;
    end else begin
      busy     <= busy_nxt;
      sb_empty <= (busy_nxt == '0);
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - NR-read / NW-write MIPS32 GPR file with scoreboard (option: REGFILE_BYPASS_EN)
module regfile_mp
  import rf_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int NR = 4,
  parameter int NW = 2,
  localparam int NREGS = 2 ** AW
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  logic [DW-1:0]    regs [NREGS];
  logic [NREGS-1:0] busy;

  regfile_scoreboard #(
    .AW(AW),
    .NW(NW)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .we       (bus.we),
    .waddr    (bus.waddr),
    .iss_en   (bus.iss_en),
    .iss_addr (bus.iss_addr),
    .busy     (busy),
    .sb_empty (bus.sb_empty)
  );

  // Storage: ports applied in ascending order so the highest index wins
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int i = 0; i < NW; i++) begin
        if (bus.we[i] && bus.waddr[i*AW +: AW] != AW'(ZERO_ADDR))
          regs[bus.waddr[i*AW +: AW]] <= bus.wdata[i*DW +: DW];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic [31:0] hit;
  int          sel;
`endif

  // Read ports: zero for disabled ports, $zero and during reset
  always_comb begin
    bus.rdata = '0;
    bus.rbusy = '0;
`ifdef REGFILE_BYPASS_EN
    hit = '0;
    sel = -1;
`endif
    if (!rst) begin
      for (int j = 0; j < NR; j++) begin
        if (bus.re[j] && bus.raddr[j*AW +: AW] != AW'(ZERO_ADDR)) begin
          bus.rdata[j*DW +: DW] = regs[bus.raddr[j*AW +: AW]];
          bus.rbusy[j]          = busy[bus.raddr[j*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
          // A value being written back this cycle is forwarded and
          // the register is no longer a stall source
          hit = '0;
          for (int i = 0; i < NW; i++)
            hit[i] = bus.we[i] && (bus.waddr[i*AW +: AW] == bus.raddr[j*AW +: AW]);
          sel = prio_sel(hit);
          if (sel >= 0) begin
            bus.rdata[j*DW +: DW] = bus.wdata[sel*DW +: DW];
            bus.rbusy[j]          = 1'b0;
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;
  localparam int NW = 2;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  regfile_mp_if #(.DW(DW), .AW(AW), .NR(NR), .NW(NW)) bus ();

  regfile_mp #(.DW(DW), .AW(AW), .NR(NR), .NW(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we       = '0;
    bus.waddr    = '0;
    bus.wdata    = '0;
    bus.re       = '0;
    bus.raddr    = '0;
    bus.iss_en   = '0;
    bus.iss_addr = '0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.we[p]             = 1'b1;
    bus.waddr[p*AW +: AW] = a;
    bus.wdata[p*DW +: DW] = d;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a);
    bus.re[p]             = 1'b1;
    bus.raddr[p*AW +: AW] = a;
  endtask

  task automatic iss(input int k, input logic [AW-1:0] a);
    bus.iss_en[k]            = 1'b1;
    bus.iss_addr[k*AW +: AW] = a;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    rd(0, 5'd1);
    #1;
    chk("reset_sb_empty", 128'(bus.sb_empty), 128'd1);
    chk("reset_rdata", 128'(bus.rdata[31:0]), 128'd0);
    idle();

    // 1. Reset clears storage
    wr(0, 5'd5, 32'h1234);
    tick();
    idle();
    rd(0, 5'd5);
    #1;
    chk("t1_r5_written", 128'(bus.rdata[31:0]), 128'h1234);
    rst = 1'b1;
    #1;
    chk("t1_rdata_in_rst", 128'(bus.rdata[31:0]), 128'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("t1_r5_after_rst", 128'(bus.rdata[31:0]), 128'd0);
    chk("t1_sb_empty", 128'(bus.sb_empty), 128'd1);
    chk("t1_rbusy", 128'(bus.rbusy), 128'd0);
    idle();

    // 2. Write conflict and $zero
    wr(0, 5'd7, 32'hAAAA);
    wr(1, 5'd7, 32'h5555);
    tick();
    idle();
    rd(0, 5'd7);
    #1;
    chk("t2_conflict_r7", 128'(bus.rdata[31:0]), 128'h5555);
    bus.re = '0;
    #1;
    chk("t2_re_off", 128'(bus.rdata[31:0]), 128'd0);
    idle();
    wr(0, 5'd0, 32'hFFFF);
    tick();
    idle();
    rd(0, 5'd0);
    #1;
    chk("t2_r0_zero", 128'(bus.rdata[31:0]), 128'd0);
    idle();

    // 3. Scoreboard, issue r9 in cycle 0, write back in cycle 3
    iss(0, 5'd9);
    tick();
    idle();
    rd(0, 5'd9);
    #1;
    chk("t3_busy_c1", 128'(bus.rbusy[0]), 128'd1);
    chk("t3_sb_empty_c1", 128'(bus.sb_empty), 128'd0);
    tick();
    chk("t3_busy_c2", 128'(bus.rbusy[0]), 128'd1);
    tick();
    wr(0, 5'd9, 32'h42);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("t3_rbusy_c3", 128'(bus.rbusy[0]), 128'd0);
    chk("t3_rdata_c3", 128'(bus.rdata[31:0]), 128'h42);
`else
    chk("t3_rbusy_c3", 128'(bus.rbusy[0]), 128'd1);
    chk("t3_rdata_c3", 128'(bus.rdata[31:0]), 128'd0);
`endif
    tick();
    bus.we = '0;
    #1;
    chk("t3_rbusy_c4", 128'(bus.rbusy[0]), 128'd0);
    chk("t3_rdata_c4", 128'(bus.rdata[31:0]), 128'h42);
    chk("t3_sb_empty_c4", 128'(bus.sb_empty), 128'd1);
    idle();

    // Issue to $zero is ignored
    iss(1, 5'd0);
    tick();
    idle();
    chk("t3_iss_r0", 128'(bus.sb_empty), 128'd1);

    // 4. Set wins over clear on the same register
    iss(0, 5'd12);
    wr(1, 5'd12, 32'h77);
    tick();
    idle();
    rd(2, 5'd12);
    #1;
    chk("t4_r12_busy", 128'(bus.rbusy[2]), 128'd1);
    chk("t4_r12_data", 128'(bus.rdata[95:64]), 128'h77);
    chk("t4_sb_empty", 128'(bus.sb_empty), 128'd0);
    wr(0, 5'd12, 32'h88);
    tick();
    bus.we = '0;
    #1;
    chk("t4_r12_cleared", 128'(bus.rbusy[2]), 128'd0);
    chk("t4_sb_empty_after", 128'(bus.sb_empty), 128'd1);
    idle();

    // 5. Four read ports with one disabled
    wr(0, 5'd1, 32'h11111111);
    wr(1, 5'd31, 32'h31313131);
    tick();
    idle();
    rd(0, 5'd1);
    rd(1, 5'd0);
    rd(3, 5'd31);
    bus.raddr[2*AW +: AW] = 5'd1;
    #1;
    chk("t5_rdata_all", 128'(bus.rdata),
        {32'h31313131, 32'h0, 32'h0, 32'h11111111});
    chk("t5_rbusy_all", 128'(bus.rbusy), 128'd0);
    idle();

    // 6. Reset while producers and a write are pending
    iss(0, 5'd3);
    iss(1, 5'd4);
    tick();
    idle();
    chk("t6_busy_before", 128'(bus.sb_empty), 128'd0);
    wr(0, 5'd3, 32'hDEAD);
    wr(1, 5'd4, 32'hBEEF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    rd(0, 5'd3);
    rd(1, 5'd4);
    #1;
    chk("t6_sb_empty", 128'(bus.sb_empty), 128'd1);
    chk("t6_rbusy", 128'(bus.rbusy), 128'd0);
    chk("t6_r3", 128'(bus.rdata[31:0]), 128'd0);
    chk("t6_r4", 128'(bus.rdata[63:32]), 128'd0);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
